// File: rtl/uram_pkg.sv
// Defaults and state encoding shared by the URAM scan readers.
package uram_pkg;

  localparam int URAM_WIDTH  = 3072;
  localparam int URAM_ADDR_W = 12;
  localparam int URAM_RD_LAT = 2;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } scan_state_e;

endpackage

// File: rtl/scan_prio_enc.sv
// Lowest-set-bit encoder over a W-bit window; found is low for an all-zero window.
module scan_prio_enc #(
  parameter  int W  = 16,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    found_o = |vec_i;
    idx_o   = '0;
    // Walk downward so the lowest set bit is the last one written.
    for (int k = W - 1; k >= 0; k--) begin
      if (vec_i[k]) idx_o = IW'(k);
    end
  end

endmodule

// File: rtl/uram_scan_reader.sv
// Scans an exponent vector and issues one pipelined URAM read per set bit,
// forwarding each returned word with its bit index to a credit-limited FIFO.
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | walking windows of pend, issuing reads while credits allow
// DRAIN | no new reads; waiting for in-flight reads to land in the FIFO
module uram_scan_reader
  import uram_pkg::*;
#(
  parameter int WIDTH  = URAM_WIDTH,
  parameter int ADDR_W = URAM_ADDR_W,
  parameter int NBITS  = 2 ** ADDR_W,
  parameter int SCAN_W = 16,
  parameter int RD_LAT = URAM_RD_LAT,
  parameter int FREE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NBITS-1:0]  e,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  input  logic [FREE_W-1:0] fifo_free,
  output logic              fifo_wr,
  output logic [WIDTH-1:0]  fifo_data,
  output logic [ADDR_W-1:0] fifo_tag
);

  localparam int IDX_W = $clog2(SCAN_W);
  localparam int SEG_W = ADDR_W - IDX_W;
  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(NBITS / SCAN_W - 1);

  scan_state_e       state_q;
  logic [NBITS-1:0]  pend_q;
  logic [SEG_W-1:0]  seg_q;
  logic [FREE_W-1:0] out_q, out_d;
  logic              rd_en_q, busy_q, done_q, aborted_q;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [RD_LAT-1:0] pipe_v_q;
  logic [ADDR_W-1:0] pipe_a_q [RD_LAT];

  logic [SCAN_W-1:0] window;
  logic [IDX_W-1:0]  idx;
  logic              found, issue, drained;

  // Segment number forms the upper address bits since NBITS == 2**ADDR_W.
  assign window = pend_q[{seg_q, {IDX_W{1'b0}}} +: SCAN_W];

  scan_prio_enc #(.W(SCAN_W)) u_prio_enc (
    .vec_i   (window),
    .found_o (found),
    .idx_o   (idx)
  );

  always_comb begin
    rd_addr_d = {seg_q, idx};
    issue     = (state_q == SCAN) && !abort && found && (out_q < fifo_free);
    out_d     = out_q + FREE_W'(issue) - FREE_W'(pipe_v_q[RD_LAT-1]);
    drained   = (out_q == '0) && !rd_en_q && (pipe_v_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      seg_q     <= '0;
      out_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      pipe_v_q  <= '0;
      for (int k = 0; k < RD_LAT; k++) pipe_a_q[k] <= '0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= out_d;

      pipe_v_q[0] <= rd_en_q;
      pipe_a_q[0] <= rd_addr_q;
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_v_q[k] <= pipe_v_q[k-1];
        pipe_a_q[k] <= pipe_a_q[k-1];
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            pend_q    <= e;
            seg_q     <= '0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= (e == '0) ? DRAIN : SCAN;
          end
        end
        SCAN: begin
          if (abort) begin
            pend_q    <= '0;
            aborted_q <= 1'b1;
            state_q   <= DRAIN;
          end else if (found) begin
            if (issue) begin
              rd_en_q           <= 1'b1;
              rd_addr_q         <= rd_addr_d;
              pend_q[rd_addr_d] <= 1'b0;
            end
          end else if (seg_q == SEG_LAST) begin
            state_q <= DRAIN;
          end else begin
            seg_q <= seg_q + SEG_W'(1);
          end
        end
        DRAIN: begin
          if (abort) aborted_q <= 1'b1;
          if (drained) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign fifo_wr   = pipe_v_q[RD_LAT-1];
  assign fifo_tag  = pipe_a_q[RD_LAT-1];
  assign fifo_data = rd_data;

endmodule

// File: tb/tb_uram_scan_reader.sv
// Scoreboard bench for uram_scan_reader: model queues of expected reads and
// writes, a URAM returning addr*3, and a downstream FIFO with credit output.
module tb_uram_scan_reader;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 6;
  localparam int NBITS  = 64;
  localparam int SCAN_W = 8;
  localparam int RD_LAT = 2;
  localparam int FREE_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [NBITS-1:0]  e = '0;
  logic              busy, done, aborted, rd_en, fifo_wr;
  logic [ADDR_W-1:0] rd_addr, fifo_tag;
  logic [WIDTH-1:0]  rd_data, fifo_data;
  logic [FREE_W-1:0] fifo_free = '0;

  uram_scan_reader #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .NBITS(NBITS),
    .SCAN_W(SCAN_W), .RD_LAT(RD_LAT), .FREE_W(FREE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .e(e), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .fifo_free(fifo_free), .fifo_wr(fifo_wr),
    .fifo_data(fifo_data), .fifo_tag(fifo_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // URAM model: data for an address appears RD_LAT cycles after the strobe.
  logic [ADDR_W-1:0] ur_a [RD_LAT];
  always @(posedge clk) begin
    ur_a[0] <= rd_addr;
    for (int k = 1; k < RD_LAT; k++) ur_a[k] <= ur_a[k-1];
  end
  assign rd_data = WIDTH'(ur_a[RD_LAT-1]) * 3;

  int n_checks = 0, n_pass = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Downstream FIFO: occupancy grows on fifo_wr, optionally drains at random.
  int occ = 0, cap = 16;
  bit drain_en = 1'b1, fifo_clr = 1'b0;
  always @(negedge clk) begin
    if (fifo_clr || !rst_n) occ = 0;
    else begin
      if (fifo_wr) begin
        check(occ < cap, "fifo_overflow", occ + 1, cap);
        occ++;
      end
      if (drain_en && occ > 0 && $urandom_range(0, 1) == 1) occ--;
    end
    fifo_free = FREE_W'(cap - occ);
  end

  typedef struct { int c; int a; } wr_exp_t;
  int      exp_issue[$];
  wr_exp_t exp_wr[$];
  int      iss_cyc[$];
  bit      exp_abort = 1'b0;
  int      abort_cyc = 1 << 30;
  int      rd_cnt = 0, wr_cnt = 0, done_cnt = 0, done_base = 0;
  int      done_cyc = 0, last_wr_cyc = 0, start_cyc = 0;

  // Monitor: reads must follow the model order, writes must match reads RD_LAT later.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_wr) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        check(exp_wr.size() != 0, "wr_unexpected", fifo_tag, -1);
        if (exp_wr.size() != 0) begin
          wr_exp_t w;
          w = exp_wr.pop_front();
          check(fifo_tag == ADDR_W'(w.a), "fifo_tag", fifo_tag, w.a);
          check(fifo_data == WIDTH'(w.a * 3), "fifo_data", fifo_data, w.a * 3);
          check(cyc == w.c + RD_LAT, "wr_latency", cyc - w.c, RD_LAT);
        end
      end
      if (rd_en) begin
        rd_cnt++;
        iss_cyc.push_back(cyc);
        check(cyc <= abort_cyc, "rd_after_abort", cyc, abort_cyc);
        check(exp_issue.size() != 0, "rd_unexpected", rd_addr, -1);
        if (exp_issue.size() != 0) begin
          int a;
          a = exp_issue.pop_front();
          check(rd_addr == ADDR_W'(a), "rd_addr", rd_addr, a);
          exp_wr.push_back('{c: cyc, a: a});
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check(busy == 1'b0, "busy_at_done", busy, 0);
        check(aborted == exp_abort, "aborted_flag", aborted, exp_abort);
        check(exp_wr.size() == 0, "writes_missing", exp_wr.size(), 0);
        if (!exp_abort) check(exp_issue.size() == 0, "reads_missing", exp_issue.size(), 0);
        exp_issue.delete();
      end
    end
  end

  task automatic flush_fifo();
    @(negedge clk) fifo_clr = 1'b1;
    @(negedge clk) fifo_clr = 1'b0;
  endtask

  // e is replaced by its complement right after start to show it is latched.
  task automatic launch(input logic [NBITS-1:0] ev);
    @(negedge clk);
    exp_issue.delete();
    for (int i = 0; i < NBITS; i++) if (ev[i]) exp_issue.push_back(i);
    exp_abort = 1'b0;
    abort_cyc = 1 << 30;
    rd_cnt = 0;
    wr_cnt = 0;
    iss_cyc.delete();
    done_base = done_cnt;
    e = ev;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    e = ~ev;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_cnt == done_base; k++) @(negedge clk);
    check(done_cnt != done_base, "done_timeout", done_cnt, done_base + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NBITS-1:0] ev;
    int n0;

    #1;
    check(busy == 0 && done == 0 && aborted == 0, "reset_flags", {busy, done, aborted}, 0);
    check(rd_en == 0 && fifo_wr == 0, "reset_strobes", {rd_en, fifo_wr}, 0);
    check(rd_addr == 0 && fifo_tag == 0, "reset_addr", {rd_addr, fifo_tag}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic ordering: reads at 0,4,7,63; done two cycles after the last write.
    cap = 16; drain_en = 1'b1; flush_fifo();
    launch(64'h8000_0000_0000_0091);
    wait_done(500);
    check(rd_cnt == 4, "basic_rd_cnt", rd_cnt, 4);
    check(wr_cnt == 4, "basic_wr_cnt", wr_cnt, 4);
    check(done_cyc - last_wr_cyc == 2, "basic_done_gap", done_cyc - last_wr_cyc, 2);

    // Burst of 8 without bubbles, then 8 window evaluations that find nothing.
    flush_fifo();
    launch(64'h0000_0000_0000_00FF);
    wait_done(500);
    check(iss_cyc.size() == 8, "burst_cnt", iss_cyc.size(), 8);
    if (iss_cyc.size() == 8) begin
      check(iss_cyc[0] == start_cyc + 2, "burst_first", iss_cyc[0] - start_cyc, 2);
      check(iss_cyc[7] - iss_cyc[0] == 7, "burst_bubbles", iss_cyc[7] - iss_cyc[0], 7);
      check(done_cyc - iss_cyc[7] == 9, "skip_done_gap", done_cyc - iss_cyc[7], 9);
    end

    // Back-pressure: three credits and no drain, then open up to 64 free slots.
    cap = 3; drain_en = 1'b0; flush_fifo();
    launch('1);
    repeat (40) @(negedge clk);
    check(rd_cnt == 3, "bp_stall_cnt", rd_cnt, 3);
    check(busy == 1'b1, "bp_busy", busy, 1);
    cap = 67;
    wait_done(1000);
    check(rd_cnt == 64, "bp_rd_total", rd_cnt, 64);
    check(wr_cnt == 64, "bp_wr_total", wr_cnt, 64);

    // Abort five cycles after the first read.
    cap = 200; drain_en = 1'b1; flush_fifo();
    launch('1);
    for (int k = 0; k < 200 && rd_cnt == 0; k++) @(negedge clk);
    check(rd_cnt > 0, "abort_first_rd", rd_cnt, 1);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    abort_cyc = cyc;
    exp_abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(500);
    check(rd_cnt > 0 && rd_cnt < 64, "abort_partial", rd_cnt, 32);
    check(wr_cnt == rd_cnt, "abort_all_written", wr_cnt, rd_cnt);
    check(aborted == 1'b1, "aborted_hold", aborted, 1);
    abort_cyc = 1 << 30;

    // abort while idle is ignored.
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check(busy == 1'b0 && aborted == 1'b1, "idle_abort", {busy, aborted}, 1);

    // Empty exponent: start is sampled, one DRAIN cycle, then done.
    flush_fifo();
    launch('0);
    wait_done(50);
    check(done_cyc - start_cyc == 2, "empty_done_lat", done_cyc - start_cyc, 2);
    check(rd_cnt == 0, "empty_no_rd", rd_cnt, 0);

    // A second start while busy must not disturb the running scan.
    flush_fifo();
    ev = 64'h00F0_0000_0000_0F01;
    launch(ev);
    repeat (3) @(negedge clk);
    e = 64'hFFFF_0000_FFFF_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(500);
    repeat (10) @(negedge clk);
    check(done_cnt == done_base + 1, "ignored_start", done_cnt - done_base, 1);
    check(rd_cnt == $countones(ev), "ignored_rd_cnt", rd_cnt, $countones(ev));

    // Randomised runs with varying credit depth and random drain.
    for (int r = 0; r < 6; r++) begin
      ev = {$urandom, $urandom};
      if (r % 2 == 1) ev = ev & {$urandom, $urandom} & {$urandom, $urandom};
      cap = $urandom_range(1, 20);
      drain_en = 1'b1;
      flush_fifo();
      launch(ev);
      wait_done(3000);
      check(wr_cnt == $countones(ev), "rand_wr_cnt", wr_cnt, $countones(ev));
    end

    // Reset in the middle of a burst.
    cap = 200; drain_en = 1'b1; flush_fifo();
    launch('1);
    for (int k = 0; k < 200 && rd_cnt < 5; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check(busy == 0 && done == 0 && aborted == 0, "midrst_flags", {busy, done, aborted}, 0);
    check(rd_en == 0 && fifo_wr == 0, "midrst_strobes", {rd_en, fifo_wr}, 0);
    check(rd_addr == 0 && fifo_tag == 0, "midrst_addr", {rd_addr, fifo_tag}, 0);
    exp_issue.delete();
    exp_wr.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n0 = wr_cnt;
    repeat (6) @(negedge clk);
    check(wr_cnt == n0, "stale_wr", wr_cnt - n0, 0);
    ev = {$urandom, $urandom};
    launch(ev);
    wait_done(1000);
    check(wr_cnt == $countones(ev), "post_rst_wr_cnt", wr_cnt, $countones(ev));

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uram_scan_reader.md
Name: uram_scan_reader

Overview:
- Scans an exponent bit-vector. For every set bit, issues one URAM read at the bit's index and forwards the returned word, tagged with that index, to a downstream FIFO.
- Successor of the single-outstanding scanner:
  - pipelined reads, up to one issue per clock;
  - parametrised read latency;
  - SCAN_W-bit window skip of zero runs;
  - credit-based FIFO back-pressure;
  - start/done/abort handshake.
- Sits between the pre-ME control (which supplies e) and the precompute FIFO feeding the modular-exponentiation datapath.

Parameters:
- WIDTH, 3072, URAM data word width.
- ADDR_W, 12, URAM address width.
- NBITS, 4096, exponent length (2**ADDR_W); must be a multiple of SCAN_W.
- SCAN_W, 16, bits examined per cycle by the priority encoder (power of 2).
- RD_LAT, 2, URAM read latency in cycles from rd_en to valid rd_data (≥1).
- FREE_W, 8, width of the downstream FIFO free-slot count.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; latch e and begin scan (ignored while busy)
- e  in  NBITS  exponent bit-vector
- abort  in  1  pulse; stop issuing new reads
- busy  out  1  scan or in-flight reads active
- done  out  1  one-cycle pulse at completion
- aborted  out  1  high from done until next start if the run was aborted
- rd_en  out  1  URAM read strobe (registered)
- rd_addr  out  ADDR_W  URAM read address (registered)
- rd_data  in  WIDTH  URAM read data
- fifo_free  in  FREE_W  free slots in downstream FIFO
- fifo_wr  out  1  FIFO write strobe
- fifo_data  out  WIDTH  equals rd_data (combinational pass-through)
- fifo_tag  out  ADDR_W  index of the bit that produced fifo_data

Behaviour:
- Reset clears all state. Outputs: busy, done, aborted, rd_en, fifo_wr = 0; rd_addr, fifo_tag = 0. In-flight reads are discarded.
- States: IDLE, SCAN, DRAIN.
- IDLE, start=1:
  - pend ← e, seg ← 0, aborted ← 0, busy ← 1.
  - If e == 0, go directly to DRAIN; done follows one cycle later.
- SCAN, each cycle: window = pend[seg*SCAN_W +: SCAN_W]; lowest set bit i found by priority encoder.
  - Window non-zero and outstanding < fifo_free: next cycle rd_en=1, rd_addr = seg*SCAN_W+i; clear that pend bit. seg holds.
  - Window non-zero, no credit: rd_en=0; stall with no state change.
  - Window zero: seg+1, no read. Last segment zero → DRAIN.
  - Throughput: one read per cycle while credits allow; empty windows cost one cycle each.
- Ordering: reads are issued in strictly ascending address order.
- Outstanding counter (width FREE_W):
  - +1 on each issue, −1 on each fifo_wr; both in one cycle → unchanged.
  - Never exceeds fifo_free as sampled at issue.
- Return path:
  - RD_LAT-stage shift registers carry rd_en and rd_addr.
  - fifo_wr = stage RD_LAT valid; fifo_tag = stage RD_LAT addr; fifo_data = rd_data.
  - Read issued at cycle t → fifo_wr at t+RD_LAT.
- abort: while in SCAN or DRAIN, clears pend, sets aborted, enters DRAIN. No new rd_en from the next cycle on; in-flight reads still complete and are written. abort in IDLE is ignored.
- DRAIN: wait for outstanding == 0 and an empty pipeline. Then done=1 for one cycle, busy ← 0, return to IDLE.
- start while busy: ignored, e not sampled.
- start and abort in the same IDLE cycle: start wins.

Decomposition:
- Shared package (uram_pkg): URAM_WIDTH, URAM_ADDR_W, URAM_RD_LAT defaults; state enum {IDLE, SCAN, DRAIN}.
- One sub-module: scan_prio_enc (SCAN_W-bit lowest-set-bit encoder with found flag), reused by future scanners.

Test Plan (NBITS=64, ADDR_W=6, SCAN_W=8, RD_LAT=2, WIDTH=32, URAM model returns data = addr*3):
- Basic ordering: e=0x8000_0000_0000_0091, fifo_free=16 → reads at 0,4,7,63. fifo_data 0,12,21,189 with matching tags. Done exactly 2 cycles after the last fifo_wr.
- Back-to-back and skip: e=0x0000_0000_0000_00FF → 8 consecutive rd_en cycles (addr 0..7). Then 7 zero segments skipped in 7 cycles; done; no bubbles within the burst.
- Back-pressure: e=all ones, fifo_free held at 3 with no FIFO drain → exactly 3 rd_en issued, then stall. Raise fifo_free to 64 → remaining 61 issued; 64 writes total, tags 0..63 in order.
- Abort: e=all ones; abort pulsed 5 cycles after the first rd_en → no rd_en after the abort cycle. All issued reads reach the FIFO; done pulses with aborted=1.
- Empty and ignored start: e=0 → done one cycle after start with zero rd_en. A second start while busy on another run is ignored.
- Reset mid-run: rst_n low during a burst → all outputs 0 immediately. After release, no stale fifo_wr; a new start works normally.
